// File: rtl/sync_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sync_counter_ctrl
// Description : Start/stop/abort sequencer for an external sync_counter_8bit.
//               It provides one-shot and periodic run modes and a saturating
//               count of completed periods.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_counter_ctrl #(
    parameter int W        = 8,
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                cmd_start,
    input  logic                cmd_stop,
    input  logic                cmd_abort,
    input  logic                mode,
    input  logic [W-1:0]        preset,
    input  logic [W-1:0]        target,
    input  logic [W-1:0]        cnt_c,
    output logic                cnt_l,
    output logic                cnt_s_s,
    output logic [W-1:0]        cnt_d,
    output logic                cnt_clr,
    output logic                busy,
    output logic                done,
    output logic                tick,
    output logic [PERIOD_W-1:0] periods
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [PERIOD_W-1:0] c_PERIODS_MAX = {PERIOD_W{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W-1:0]        r_preset;
    logic [W-1:0]        r_target;
    logic                r_mode;
    logic [PERIOD_W-1:0] r_periods;
    logic                r_cnt_clr;

    logic                w_match;
    logic                w_latch;
    logic                w_period_clr;
    logic                w_period_inc;

    assign w_match = (cnt_c == r_target);

    // Abort is checked before any per-state decision so it wins everywhere.
    always_comb begin
        w_state_nxt  = r_state;
        w_latch      = 1'b0;
        w_period_clr = 1'b0;
        w_period_inc = 1'b0;
        if (cmd_abort) begin
            w_state_nxt  = S_IDLE;
            w_period_clr = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (cmd_start) begin
                        w_state_nxt  = S_LOAD;
                        w_latch      = 1'b1;
                        w_period_clr = 1'b1;
                    end
                end
                S_LOAD: begin
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (w_match) begin
                        w_period_inc = 1'b1;
                        if (!r_mode) begin
                            w_state_nxt = S_DONE;
                        end else if (cmd_stop) begin
                            w_state_nxt = S_PAUSE;
                        end
                    end else if (cmd_stop) begin
                        w_state_nxt = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (cmd_start && !cmd_stop) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_preset <= '0;
            r_target <= '0;
            r_mode   <= 1'b0;
        end else if (w_latch) begin
            r_preset <= preset;
            r_target <= target;
            r_mode   <= mode;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_periods <= '0;
        end else if (w_period_clr) begin
            r_periods <= '0;
        end else if (w_period_inc && (r_periods != c_PERIODS_MAX)) begin
            r_periods <= r_periods + 1'b1;
        end
    end

    // Clear pulse is issued in the cycle after the abort edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt_clr <= 1'b0;
        end else begin
            r_cnt_clr <= cmd_abort;
        end
    end

    assign cnt_l   = (r_state == S_LOAD) || ((r_state == S_RUN) && w_match && r_mode);
    assign cnt_s_s = (r_state == S_RUN) && !w_match;
    assign tick    = (r_state == S_RUN) && w_match;
    assign cnt_d   = r_preset;
    assign cnt_clr = r_cnt_clr;
    assign busy    = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_PAUSE);
    assign done    = (r_state == S_DONE);
    assign periods = r_periods;

endmodule
`default_nettype wire

// File: tb/tb_sync_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_counter_ctrl
// Description : Directed self-checking bench for sync_counter_ctrl that uses
//               a behavioural model of the counter it controls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_counter_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       cmd_start = 1'b0;
    logic       cmd_stop  = 1'b0;
    logic       cmd_abort = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] preset = 8'h00;
    logic [7:0] target = 8'h00;
    logic [7:0] cnt_c;
    logic       cnt_l;
    logic       cnt_s_s;
    logic [7:0] cnt_d;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic       tick;
    logic [7:0] periods;

    int checks = 0;
    int errors = 0;

    sync_counter_ctrl #(.W(8), .PERIOD_W(8)) dut (
        .clk      (clk),
        .clr      (clr),
        .cmd_start(cmd_start),
        .cmd_stop (cmd_stop),
        .cmd_abort(cmd_abort),
        .mode     (mode),
        .preset   (preset),
        .target   (target),
        .cnt_c    (cnt_c),
        .cnt_l    (cnt_l),
        .cnt_s_s  (cnt_s_s),
        .cnt_d    (cnt_d),
        .cnt_clr  (cnt_clr),
        .busy     (busy),
        .done     (done),
        .tick     (tick),
        .periods  (periods)
    );

    always #5 clk = ~clk;

    // Model of sync_counter_8bit: clear, then load, then count.
    always @(posedge clk or posedge clr) begin
        if (clr)          cnt_c <= 8'h00;
        else if (cnt_clr) cnt_c <= 8'h00;
        else if (cnt_l)   cnt_c <= cnt_d;
        else if (cnt_s_s) cnt_c <= cnt_c + 8'h01;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; cmd_start = 1'b1; cmd_stop = 1'b1; cmd_abort = 1'b1; mode = 1'b1;
        cyc(); cyc();
        checks++;
        if ({cnt_l, cnt_s_s, cnt_clr, busy, done, tick} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000", {cnt_l, cnt_s_s, cnt_clr, busy, done, tick});
        end
        checks++;
        if (periods !== 8'h00 || cnt_d !== 8'h00) begin
            errors++; $display("FAIL reset_regs got periods=%h d=%h exp 00 00", periods, cnt_d);
        end
        cmd_start = 1'b0; cmd_stop = 1'b0; cmd_abort = 1'b0; mode = 1'b0;
        clr = 1'b0;
        cyc();
        checks++;
        if (busy !== 1'b0 || cnt_l !== 1'b0) begin
            errors++; $display("FAIL reset_idle got busy=%b l=%b exp 0 0", busy, cnt_l);
        end
    endtask

    task automatic test_one_shot();
        preset = 8'h10; target = 8'h14; mode = 1'b0; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        checks++;
        if (cnt_l !== 1'b1 || busy !== 1'b1 || cnt_d !== 8'h10) begin
            errors++; $display("FAIL os_load got l=%b busy=%b d=%h exp 1 1 10", cnt_l, busy, cnt_d);
        end
        cyc();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cnt_c !== 8'h10 + 8'(i) || tick !== (i == 4) || cnt_l !== 1'b0) begin
                errors++;
                $display("FAIL os_run[%0d] got c=%h tick=%b l=%b exp %h %b 0", i, cnt_c, tick, cnt_l, 8'h10 + 8'(i), (i == 4));
            end
            cyc();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cnt_c !== 8'h14 || periods !== 8'h01) begin
            errors++; $display("FAIL os_done got done=%b busy=%b c=%h p=%h exp 1 0 14 01", done, busy, cnt_c, periods);
        end
        preset = 8'h55; target = 8'h66;
        cyc(); cyc();
        checks++;
        if (done !== 1'b1 || cnt_c !== 8'h14 || cnt_d !== 8'h10 || cnt_s_s !== 1'b0) begin
            errors++; $display("FAIL os_hold got done=%b c=%h d=%h s=%b exp 1 14 10 0", done, cnt_c, cnt_d, cnt_s_s);
        end
    endtask

    task automatic test_periodic();
        logic [7:0] seq [4];
        seq[0] = 8'hFE; seq[1] = 8'hFF; seq[2] = 8'h00; seq[3] = 8'h01;
        preset = 8'hFE; target = 8'h01; mode = 1'b1; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        checks++;
        if (periods !== 8'h00 || cnt_l !== 1'b1) begin
            errors++; $display("FAIL per_load got p=%h l=%b exp 00 1", periods, cnt_l);
        end
        cyc();
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (cnt_c !== seq[j] || tick !== (j == 3) || cnt_l !== (j == 3) || periods !== 8'(p)) begin
                    errors++;
                    $display("FAIL per_seq[%0d.%0d] got c=%h tick=%b l=%b p=%h exp %h %b %b %h",
                             p, j, cnt_c, tick, cnt_l, periods, seq[j], (j == 3), (j == 3), 8'(p));
                end
                cyc();
            end
        end
        checks++;
        if (periods !== 8'h03 || cnt_c !== 8'hFE || busy !== 1'b1) begin
            errors++; $display("FAIL per_three got p=%h c=%h busy=%b exp 03 FE 1", periods, cnt_c, busy);
        end
        for (int n = 0; n < 257 * 4; n++) cyc();
        checks++;
        if (periods !== 8'hFF || cnt_c !== 8'hFE) begin
            errors++; $display("FAIL per_sat got p=%h c=%h exp FF FE", periods, cnt_c);
        end
        cmd_abort = 1'b1;
        cyc();
        cmd_abort = 1'b0;
        checks++;
        if (periods !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL per_abort got p=%h busy=%b exp 00 0", periods, busy);
        end
        cyc();
    endtask

    task automatic test_pause();
        preset = 8'h10; target = 8'h40; mode = 1'b0; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        cyc(); cyc();
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        checks++;
        if (cnt_c !== 8'h12 || cnt_s_s !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL pause_enter got c=%h s=%b busy=%b exp 12 0 1", cnt_c, cnt_s_s, busy);
        end
        for (int n = 0; n < 10; n++) cyc();
        checks++;
        if (cnt_c !== 8'h12 || busy !== 1'b1) begin
            errors++; $display("FAIL pause_hold got c=%h busy=%b exp 12 1", cnt_c, busy);
        end
        cmd_start = 1'b1; cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        checks++;
        if (cnt_c !== 8'h12 || cnt_s_s !== 1'b0) begin
            errors++; $display("FAIL pause_both got c=%h s=%b exp 12 0", cnt_c, cnt_s_s);
        end
        cyc();
        cmd_start = 1'b0;
        checks++;
        if (cnt_s_s !== 1'b1 || cnt_l !== 1'b0) begin
            errors++; $display("FAIL pause_resume got s=%b l=%b exp 1 0", cnt_s_s, cnt_l);
        end
        cyc();
        checks++;
        if (cnt_c !== 8'h13) begin
            errors++; $display("FAIL pause_noreload got c=%h exp 13", cnt_c);
        end
    endtask

    task automatic test_abort();
        for (int n = 0; n < 32; n++) cyc();
        checks++;
        if (cnt_c !== 8'h33 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre got c=%h busy=%b exp 33 1", cnt_c, busy);
        end
        cmd_abort = 1'b1;
        cyc();
        cmd_abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cnt_clr !== 1'b1 || periods !== 8'h00 || cnt_s_s !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b clr=%b p=%h s=%b exp 0 1 00 0", busy, cnt_clr, periods, cnt_s_s);
        end
        cyc();
        checks++;
        if (cnt_clr !== 1'b0 || cnt_c !== 8'h00) begin
            errors++; $display("FAIL abort_clr got clr=%b c=%h exp 0 00", cnt_clr, cnt_c);
        end
    endtask

    task automatic test_equal();
        preset = 8'h20; target = 8'h20; mode = 1'b0; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        cyc();
        checks++;
        if (cnt_c !== 8'h20 || tick !== 1'b1 || cnt_s_s !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL eq_run got c=%h tick=%b s=%b done=%b exp 20 1 0 0", cnt_c, tick, cnt_s_s, done);
        end
        cyc();
        checks++;
        if (done !== 1'b1 || cnt_c !== 8'h20 || periods !== 8'h01) begin
            errors++; $display("FAIL eq_done got done=%b c=%h p=%h exp 1 20 01", done, cnt_c, periods);
        end
        mode = 1'b1; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tick !== 1'b1 || cnt_c !== 8'h20 || periods !== 8'(i)) begin
                errors++; $display("FAIL eq_per[%0d] got tick=%b c=%h p=%h exp 1 20 %h", i, tick, cnt_c, periods, 8'(i));
            end
            cyc();
        end
        #2 clr = 1'b1;
        #1;
        checks++;
        if ({busy, done, tick, cnt_l, cnt_s_s, cnt_clr} !== 6'b0 || periods !== 8'h00 || cnt_d !== 8'h00) begin
            errors++; $display("FAIL async_clr got ctl=%b p=%h d=%h exp 000000 00 00",
                               {busy, done, tick, cnt_l, cnt_s_s, cnt_clr}, periods, cnt_d);
        end
        cyc();
        clr = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_pause();
        test_abort();
        test_equal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
